// File: rtl/frac_pwm_pkg.sv
// Shared constants and helpers for the multi-channel fractional PWM.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package frac_pwm_pkg;

  localparam int FRAC_PWM_WIDTH = 17;
  localparam int FRAC_PWM_FRAC  = 3;
  localparam int FRAC_PWM_NCH   = 4;

  // High count for one period: integer duty plus the dither carry, clamped
  // to the period length (period+1 clocks). Works on 32-bit values so any
  // WIDTH up to 31 fits without overflow; callers zero-extend and truncate.
  function automatic logic [31:0] sat_hi(input logic [31:0] duty_int,
                                         input logic        carry,
                                         input logic [31:0] period);
    logic [31:0] hi;
    logic [31:0] lim;
    hi  = duty_int + {31'd0, carry};
    lim = period + 32'd1;
    return (hi > lim) ? lim : hi;
  endfunction

endpackage

// File: rtl/frac_pwm_mc_if.sv
// Host-side bundle of the PWM block: period, shadow write port and outputs.
// Latency: n/a (wires only).
// Backpressure: none; writes are always accepted. Optional FRAC_PWM_POL_EN adds pol_inv.
interface frac_pwm_mc_if
  import frac_pwm_pkg::*;
#(
  parameter int WIDTH = FRAC_PWM_WIDTH,
  parameter int FRAC  = FRAC_PWM_FRAC,
  parameter int NCH   = FRAC_PWM_NCH,
  parameter int CHW   = (NCH > 1) ? $clog2(NCH) : 1
);

  logic [WIDTH-1:0] period;
  logic             wr_en;
  logic [CHW-1:0]   wr_ch;
  logic [WIDTH-1:0] wr_int;
  logic [FRAC-1:0]  wr_frac;
`ifdef FRAC_PWM_POL_EN
  logic [NCH-1:0]   pol_inv;
`endif
  logic [NCH-1:0]   q_out;
  logic             period_start;
  logic [NCH-1:0]   pending;

`ifdef FRAC_PWM_POL_EN
  modport master (output period, wr_en, wr_ch, wr_int, wr_frac, pol_inv,
                  input  q_out, period_start, pending);
  modport slave  (input  period, wr_en, wr_ch, wr_int, wr_frac, pol_inv,
                  output q_out, period_start, pending);
`else
  modport master (output period, wr_en, wr_ch, wr_int, wr_frac,
                  input  q_out, period_start, pending);
  modport slave  (input  period, wr_en, wr_ch, wr_int, wr_frac,
                  output q_out, period_start, pending);
`endif

endinterface

// File: rtl/frac_pwm_ch.sv
// One PWM channel: shadow/active duty, dither accumulator and high-time counter.
// Latency: shadow reaches q one clock after the wrap edge that commits it.
// Backpressure: none. Optional FRAC_PWM_POL_EN adds a committed output polarity.
module frac_pwm_ch
  import frac_pwm_pkg::*;
#(
  parameter int WIDTH = FRAC_PWM_WIDTH,
  parameter int FRAC  = FRAC_PWM_FRAC
) (
  input  logic             sys_clk,
  input  logic             sync_rst_n,
  input  logic             wrap,
  input  logic [WIDTH-1:0] period,
  input  logic             wr_hit,
  input  logic [WIDTH-1:0] wr_int,
  input  logic [FRAC-1:0]  wr_frac,
`ifdef FRAC_PWM_POL_EN
  input  logic             wr_pol,
`endif
  output logic             q,
  output logic             pending
);

  // High counter needs one extra bit: a saturated count can reach period+1.
  localparam int HW = WIDTH + 1;

  logic [WIDTH-1:0] shadow_int;
  logic [WIDTH-1:0] act_int;
  logic [WIDTH-1:0] int_use;
  logic [FRAC-1:0]  shadow_frac;
  logic [FRAC-1:0]  act_frac;
  logic [FRAC-1:0]  frac_use;
  logic [FRAC-1:0]  acc;
  logic [FRAC:0]    sum;
  logic [HW-1:0]    hi;
  logic [HW-1:0]    hcnt;
  logic [HW-1:0]    hcnt_nxt;
  logic             level;
`ifdef FRAC_PWM_POL_EN
  logic             shadow_pol;
  logic             act_pol;
  logic             pol_use;
`endif

  // Post-commit duty, dither sum, saturated high count and next counter value.
  always_comb begin
    int_use  = pending ? shadow_int  : act_int;
    frac_use = pending ? shadow_frac : act_frac;
    sum      = {1'b0, acc} + {1'b0, frac_use};
    hi       = HW'(sat_hi(32'(int_use), sum[FRAC], 32'(period)));
    hcnt_nxt = hcnt;
    if (wrap) begin
      hcnt_nxt = hi;
    end else if (hcnt != '0) begin
      hcnt_nxt = hcnt - HW'(1);
    end
`ifdef FRAC_PWM_POL_EN
    pol_use = (wrap && pending) ? shadow_pol : act_pol;
    level   = (hcnt_nxt != '0) ^ pol_use;
`else
    level   = (hcnt_nxt != '0);
`endif
  end

  // Shadow capture, commit at wrap, accumulator update and registered output.
  always_ff @(posedge sys_clk) begin
    if (!sync_rst_n) begin
      shadow_int  <= '0;
      shadow_frac <= '0;
      act_int     <= '0;
      act_frac    <= '0;
      acc         <= '0;
      pending     <= 1'b0;
      hcnt        <= '0;
      q           <= 1'b0;
`ifdef FRAC_PWM_POL_EN
      shadow_pol  <= 1'b0;
      act_pol     <= 1'b0;
`endif
    end else begin
      if (wr_hit) begin
        shadow_int  <= wr_int;
        shadow_frac <= wr_frac;
`ifdef FRAC_PWM_POL_EN
        shadow_pol  <= wr_pol;
`endif
      end
      if (wrap) begin
        if (pending) begin
          act_int  <= shadow_int;
          act_frac <= shadow_frac;
        end
        acc <= sum[FRAC-1:0];
      end
`ifdef FRAC_PWM_POL_EN
      act_pol <= pol_use;
`endif
      // A write landing on the wrap cycle keeps the flag so it commits next wrap.
      if (wr_hit) begin
        pending <= 1'b1;
      end else if (wrap) begin
        pending <= 1'b0;
      end
      hcnt <= hcnt_nxt;
      q    <= level;
    end
  end

endmodule

// File: rtl/frac_pwm_mc.sv
// Multi-channel fractional PWM: shared period counter feeding NCH dithered channels.
// Latency: period_start and q_out update one clock after the wrap edge; all outputs registered.
// Backpressure: none; host writes always accepted. FRAC_PWM_POL_EN enables per-channel pol_inv.
module frac_pwm_mc
  import frac_pwm_pkg::*;
#(
  parameter int WIDTH = FRAC_PWM_WIDTH,
  parameter int FRAC  = FRAC_PWM_FRAC,
  parameter int NCH   = FRAC_PWM_NCH,
  parameter int CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic          sys_clk,
  input  logic          sync_rst_n,
  frac_pwm_mc_if.slave  bus
);

  logic [WIDTH-1:0] pcnt;
  logic             wrap;
  logic             pstart;
  logic [NCH-1:0]   wr_hit;
  logic [NCH-1:0]   q;
  logic [NCH-1:0]   pend;

  assign wrap = (pcnt == '0);

  // Shared down-counter; reloads from period at zero and flags the period start.
  always_ff @(posedge sys_clk) begin
    if (!sync_rst_n) begin
      pcnt   <= '0;
      pstart <= 1'b0;
    end else begin
      pcnt   <= wrap ? bus.period : (pcnt - WIDTH'(1));
      pstart <= wrap;
    end
  end

  // One-hot write decode; channel indices at or above NCH select nothing.
  always_comb begin
    wr_hit = '0;
    for (int k = 0; k < NCH; k++) begin
      wr_hit[k] = bus.wr_en && (bus.wr_ch == CHW'(k));
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    frac_pwm_ch #(
      .WIDTH (WIDTH),
      .FRAC  (FRAC)
    ) u_ch (
      .sys_clk    (sys_clk),
      .sync_rst_n (sync_rst_n),
      .wrap       (wrap),
      .period     (bus.period),
      .wr_hit     (wr_hit[k]),
      .wr_int     (bus.wr_int),
      .wr_frac    (bus.wr_frac),
`ifdef FRAC_PWM_POL_EN
      .wr_pol     (bus.pol_inv[k]),
`endif
      .q          (q[k]),
      .pending    (pend[k])
    );
  end

  assign bus.q_out        = q;
  assign bus.period_start = pstart;
  assign bus.pending      = pend;

endmodule

// File: tb/tb_frac_pwm_mc.sv
// Directed bench for frac_pwm_mc with period 9 (10 clocks) and FRAC=3.
// Latency: n/a.
// Backpressure: n/a.
module tb_frac_pwm_mc;

  localparam int WIDTH = 17;
  localparam int FRAC  = 3;
  localparam int NCH   = 4;
  localparam int PER   = 10;

  logic sys_clk;
  logic sync_rst_n;
  int   n_checks;
  int   n_errors;
  int   hc[NCH];
  int   frac_exp[8] = '{4, 4, 5, 4, 4, 5, 4, 5};
  int   total;
  int   cnt;

  frac_pwm_mc_if #(.WIDTH(WIDTH), .FRAC(FRAC), .NCH(NCH)) bus ();

  frac_pwm_mc #(.WIDTH(WIDTH), .FRAC(FRAC), .NCH(NCH)) dut (
    .sys_clk    (sys_clk),
    .sync_rst_n (sync_rst_n),
    .bus        (bus)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic write_ch(input int ch, input int di, input int df);
    bus.wr_en   = 1'b1;
    bus.wr_ch   = 2'(ch);
    bus.wr_int  = WIDTH'(di);
    bus.wr_frac = FRAC'(df);
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.period_start && n < 40);
    check_eq("start_seen", bus.period_start, 1);
  endtask

  // Samples one full period starting at its first clock; leaves us at the next first clock.
  task automatic measure();
    for (int c = 0; c < NCH; c++) hc[c] = 0;
    for (int i = 0; i < PER; i++) begin
      for (int c = 0; c < NCH; c++) hc[c] += int'(bus.q_out[c]);
      tick();
    end
  endtask

  task automatic check_restart(input int n);
    for (int k = 1; k <= n; k++) begin
      tick();
      check_eq("pstart_cadence", bus.period_start, ((k - 1) % PER == 0) ? 1 : 0);
      check_eq("q_idle", bus.q_out, 0);
    end
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    sync_rst_n   = 1'b0;
    bus.period   = WIDTH'(9);
    bus.wr_en    = 1'b0;
    bus.wr_ch    = '0;
    bus.wr_int   = '0;
    bus.wr_frac  = '0;
`ifdef FRAC_PWM_POL_EN
    bus.pol_inv  = '0;
`endif
    repeat (3) tick();
    check_eq("rst_q", bus.q_out, 0);
    check_eq("rst_pstart", bus.period_start, 0);
    check_eq("rst_pending", bus.pending, 0);

    // Reset release: period_start every 10 clocks from the first cycle.
    sync_rst_n = 1'b1;
    check_restart(30);

    // Integer duty on ch0 and fractional duty on ch1.
    wait_start();
    write_ch(0, 4, 0);
    write_ch(1, 4, 3);
    check_eq("pend_after_wr", bus.pending, 4'b0011);
    wait_start();
    check_eq("pend_committed", bus.pending, 0);
    check_eq("ch0_first_high", bus.q_out[0], 1);
    total = 0;
    for (int p = 0; p < 8; p++) begin
      measure();
      check_eq("ch0_int_hi", hc[0], 4);
      check_eq("ch1_frac_hi", hc[1], frac_exp[p]);
      total += hc[1];
    end
    check_eq("ch1_frac_total", total, 35);

    // Saturation on ch2 and all-low on ch3.
    write_ch(2, 10, 7);
    write_ch(3, 0, 0);
    wait_start();
    for (int p = 0; p < 2; p++) begin
      measure();
      check_eq("ch2_sat_hi", hc[2], PER);
      check_eq("ch3_zero_hi", hc[3], 0);
    end

    // Commit collision on ch2: write on the wrap cycle.
    write_ch(2, 2, 0);
    repeat (8) tick();
    check_eq("coll_pend_before", bus.pending, 4'b0100);
    write_ch(2, 6, 0);
    check_eq("coll_pstart", bus.period_start, 1);
    check_eq("coll_pend_kept", bus.pending, 4'b0100);
    measure();
    check_eq("coll_old_hi", hc[2], 2);
    check_eq("coll_pend_clear", bus.pending, 0);
    measure();
    check_eq("coll_new_hi", hc[2], 6);

    // period=0 set mid-period is ignored until the next wrap, then every cycle wraps.
    bus.period  = WIDTH'(0);
    bus.wr_en   = 1'b1;
    bus.wr_ch   = 2'(3);
    bus.wr_int  = WIDTH'(1);
    bus.wr_frac = '0;
    cnt = 0;
    do begin
      tick();
      bus.wr_en = 1'b0;
      cnt++;
    end while (!bus.period_start && cnt < 20);
    check_eq("p0_deferred", cnt, PER);
    for (int i = 0; i < 4; i++) begin
      check_eq("p0_q_high", bus.q_out, 4'b1111);
      check_eq("p0_pstart", bus.period_start, 1);
      tick();
    end

    // Mid-period reset at pcnt=5, then restart matches the first release.
    bus.period = WIDTH'(9);
    tick();
    check_eq("mr_pstart", bus.period_start, 1);
    write_ch(1, 7, 0);
    repeat (3) tick();
    check_eq("mr_pend_before", bus.pending, 4'b0010);
    check_eq("mr_ch2_high", bus.q_out[2], 1);
    sync_rst_n = 1'b0;
    tick();
    check_eq("mr_q", bus.q_out, 0);
    check_eq("mr_pending", bus.pending, 0);
    check_eq("mr_pstart_low", bus.period_start, 0);
    sync_rst_n = 1'b1;
    check_restart(21);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/frac_pwm_mc.md
# frac_pwm_mc

Multi-channel fractional PWM generator, successor to the single-channel fractional PWM.
- One shared period counter drives NCH channels.
- Each channel has a duty of `duty_int + duty_frac/2^FRAC` counts, averaged over 2^FRAC periods by a first-order error accumulator.
- Per-channel shadow registers are written from the host register interface and committed only at the period boundary.

## Interface
- `WIDTH`, 17, width of period and integer duty.
- `FRAC`, 3, number of fractional duty bits (1..8).
- `NCH`, 4, number of PWM channels (1..16).
- `CHW`, `$clog2(NCH)` (min 1), width of the channel select.
- `sys_clk`  in  1  sole clock; all logic on posedge.
- `sync_rst_n`  in  1  reset; synchronous, active-low, sampled on posedge `sys_clk`.
- `period`  in  WIDTH  period divider P; the PWM period is P+1 clocks; sampled only at wrap.
- `wr_en`  in  1  write strobe for the channel shadow registers.
- `wr_ch`  in  CHW  channel index for the write; values >= NCH are ignored.
- `wr_int`  in  WIDTH  integer duty for the shadow.
- `wr_frac`  in  FRAC  fractional duty for the shadow.
- `q_out`  out  NCH  PWM outputs.
- `period_start`  out  1  one-clock pulse in the first cycle of each period.
- `pending`  out  NCH  per-channel flag: the shadow holds an uncommitted write.

## Operation
- **Period counter `pcnt`**
  - When `pcnt==0` (wrap): load `pcnt` from `period`.
  - Otherwise: decrement.
- **Write**
  - `wr_en` with a valid `wr_ch` updates that channel's `shadow_int`/`shadow_frac` and sets `pending[ch]`.
  - A repeat write before commit overwrites the shadow (last write wins).
- **Commit at wrap, for each channel with `pending` set**
  - `act_int`/`act_frac` take the shadow value registered before this edge.
  - `pending` clears, unless `wr_en` targets the same channel on the wrap cycle. In that case the new data lands in the shadow, `pending` stays 1, and it commits at the next wrap.
- **Fractional accumulation at wrap**
  - Sum: `{carry, acc} = acc + act_frac`, using the post-commit `act_frac`; sum is FRAC+1 bits.
  - `acc` keeps the low FRAC bits.
  - Exactly `act_frac` carries occur in every 2^FRAC consecutive periods with a constant frac.
- **High count at wrap**
  - `hi = act_int + carry`, computed in WIDTH+1 bits.
  - Saturate to `period+1`, using the `period` value loaded this wrap.
  - Load into the channel down-counter `hcnt`.
- **Output**
  - `q_out[k] = (hcnt[k] != 0)`; `hcnt` decrements while nonzero.
  - The output is high for the first `hi` clocks of the period.
- **Boundary cases**
  - `hi=0`: the output stays low all period.
  - `hi >= P+1`: the output stays high all period, continuous across wraps.
  - `period=0`: every cycle is a wrap; the output is 1 each cycle iff `hi>=1`.
  - `period` changes mid-period: ignored until the next wrap.
- **Reset** (`sync_rst_n=0` at a posedge, any time including mid-period):
  - `pcnt`, `hcnt`, `acc`, shadows, actives and `pending` all go to 0.
  - `q_out=0`, `period_start=0`.

## Timing
- First posedge with `sync_rst_n=1`: `pcnt==0`, so this is a wrap. `period_start` goes 1 in the following cycle; all channels load `hi=0`.
- `period_start` registers the wrap condition and is high for 1 clock per period, aligned with the first clock of the period.
- Write-to-effect latency: a write commits at the first wrap edge at or after the clock after `wr_en`, and is visible on `q_out` in the next cycle.
- Shadow-to-output latency is 1 clock after wrap.
- The outputs are registered and glitch-free.
- No combinational path from the inputs to the outputs.

## Configuration
- `FRAC_PWM_POL_EN`
  - Defined: adds port `pol_inv`, in, NCH bits. The per-channel `act_pol` is committed at wrap alongside the duty, and `q_out[k] = (hcnt[k]!=0) ^ act_pol[k]`. Reset value of `act_pol` is 0.
  - Undefined: there is no `pol_inv` port and the outputs are active-high only.

## Structure
- Shared package `frac_pwm_pkg`:
  - Default constants `FRAC_PWM_WIDTH=17`, `FRAC_PWM_FRAC=3`, `FRAC_PWM_NCH=4`.
  - The saturating high-count function: `sat_hi(int, carry, period)`.
- Sub-module `frac_pwm_ch`: one channel, instantiated NCH times via generate. It holds the shadow, active, `pending`, `acc` and `hcnt` registers and takes the shared wrap strobe.
- The top level holds `pcnt`, `period_start` and the write decode.

## Test plan
- **Reset/wrap:** `period=9`, release reset → `period_start` pulses every 10 clocks starting the cycle after release; all `q_out=0`.
- **Integer duty:** write ch0 `int=4`, `frac=0` → after the next wrap, `q_out[0]` is high for exactly 4 of every 10 clocks.
- **Fractional average:** ch1 `int=4`, `frac=3` (FRAC=3) → over any 8 consecutive periods, exactly 3 periods have 5 high clocks and 5 have 4; total is 35 high clocks.
- **Saturation/edges:**
  - `int=10`, `frac=7` with `period=9` → continuously high.
  - `int=0`, `frac=0` → continuously low.
  - `period=0`, `int=1` → constant high.
- **Commit collision:** write ch2 on the wrap cycle → old shadow commits, `pending[2]` stays 1, new value takes effect one period later.
- **Mid-period reset:** assert `sync_rst_n=0` for 1 clock at `pcnt=5` → next cycle, all outputs and `pending` are 0; the restart matches the reset/wrap case.
